// File: rtl/hist_accum.sv
// hist_accum: per-cell orientation histogram accumulator.
// Accumulates CELL_N gradient samples into NUM_BIN saturating bins, using a
// hard vote or a linear two-bin soft vote. It then presents the finished cell
// on a held output register with valid/ready handshaking.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_valid, i_ready  sample handshake (i_ready is combinational)
//   magnitude         gradient magnitude (MAG_W)
//   code              lower bin index of the angle (CODE_W)
//   frac              interpolation position toward bin code+1 (SOFT=1 only)
//   o_valid, o_ready  histogram handshake
//   bin               histogram, bin 0 in the LSBs
//   o_sat, o_err      a bin saturated / an illegal code was seen in this cell
module hist_accum #(
    parameter int unsigned NUM_BIN = 9,
    parameter int unsigned MAG_W   = 13,
    parameter int unsigned BIN_W   = 20,
    parameter int unsigned FRAC_W  = 4,
    parameter int unsigned CELL_N  = 64,
    parameter int unsigned SOFT    = 0,
    localparam int unsigned CODE_W = $clog2(NUM_BIN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    output logic                     i_ready,
    input  logic [MAG_W-1:0]         magnitude,
    input  logic [CODE_W-1:0]        code,
    input  logic [FRAC_W-1:0]        frac,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [BIN_W*NUM_BIN-1:0] bin,
    output logic                     o_sat,
    output logic                     o_err
);

    localparam int unsigned CNT_W = $clog2(CELL_N);
    localparam int unsigned WT_W  = FRAC_W + 1;
    localparam int unsigned MUL_W = MAG_W + WT_W;
    // One extra bit over the wider operand so the raw sum can never wrap.
    localparam int unsigned SUM_W = ((BIN_W > MAG_W) ? BIN_W : MAG_W) + 1;
    localparam logic [SUM_W-1:0] BIN_MAX = SUM_W'({BIN_W{1'b1}});

    logic [CNT_W-1:0]         cnt;
    logic [BIN_W-1:0]         acc     [NUM_BIN];
    logic [BIN_W-1:0]         acc_nxt [NUM_BIN];
    logic                     cell_sat;
    logic                     cell_err;
    logic                     sat_nxt;
    logic                     err_nxt;
    logic                     accept;
    logic                     cnt_first;
    logic                     cnt_last;
    logic                     code_ok;
    logic [CODE_W-1:0]        code_up;
    logic [WT_W-1:0]          wt;
    logic [MUL_W-1:0]         prod;
    logic [MAG_W-1:0]         lo;
    logic [MAG_W-1:0]         hi;
    logic [MAG_W-1:0]         vote_lo;
    logic [MAG_W-1:0]         vote_hi;
    logic [SUM_W-1:0]         base;
    logic [SUM_W-1:0]         add;
    logic [SUM_W-1:0]         sum;
    logic [BIN_W*NUM_BIN-1:0] bin_nxt;

    // Handshake: only the cell-closing sample waits for the output register.
    assign cnt_first = (cnt == '0);
    assign cnt_last  = (cnt == CNT_W'(CELL_N - 1));
    assign i_ready   = !(cnt_last && o_valid && !o_ready);
    assign accept    = i_valid && i_ready;

    // Vote split: lo goes to bin code, hi to the next bin (wrapping to 0).
    assign code_ok = (32'(code) < NUM_BIN);
    assign code_up = (32'(code) == NUM_BIN - 1) ? '0 : code + CODE_W'(1);
    assign wt      = WT_W'(1 << FRAC_W) - WT_W'(frac);
    assign prod    = MUL_W'(magnitude) * MUL_W'(wt);
    assign lo      = MAG_W'(prod >> FRAC_W);
    assign hi      = magnitude - lo;
    assign vote_lo = (SOFT != 0) ? lo : magnitude;
    assign vote_hi = (SOFT != 0) ? hi : '0;

    // Next working bank: clear on the first sample of a cell, then saturating add.
    always_comb begin
        sat_nxt = cnt_first ? 1'b0 : cell_sat;
        err_nxt = (cnt_first ? 1'b0 : cell_err) | !code_ok;
        base    = '0;
        add     = '0;
        sum     = '0;
        bin_nxt = '0;
        for (int b = 0; b < int'(NUM_BIN); b++) begin
            acc_nxt[b] = '0;
            base = cnt_first ? '0 : SUM_W'(acc[b]);
            add  = '0;
            if (code_ok && code == CODE_W'(b))
                add = add + SUM_W'(vote_lo);
            if (code_ok && code_up == CODE_W'(b))
                add = add + SUM_W'(vote_hi);
            sum = base + add;
            if (sum > BIN_MAX) begin
                acc_nxt[b] = BIN_MAX[BIN_W-1:0];
                sat_nxt    = 1'b1;
            end else begin
                acc_nxt[b] = sum[BIN_W-1:0];
            end
            bin_nxt[b*BIN_W +: BIN_W] = acc_nxt[b];
        end
    end

    // Working bank, sample counter and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            cell_sat <= 1'b0;
            cell_err <= 1'b0;
            for (int b = 0; b < int'(NUM_BIN); b++)
                acc[b] <= '0;
            o_valid  <= 1'b0;
            bin      <= '0;
            o_sat    <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            if (accept) begin
                cnt      <= cnt_last ? '0 : cnt + CNT_W'(1);
                acc      <= acc_nxt;
                cell_sat <= sat_nxt;
                cell_err <= err_nxt;
            end
            if (accept && cnt_last) begin
                bin     <= bin_nxt;
                o_sat   <= sat_nxt;
                o_err   <= err_nxt;
                o_valid <= 1'b1;
            end else if (o_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hist_accum.sv
// Directed bench for hist_accum: three instances share one stimulus stream
// (hard vote, soft vote, and hard vote with 8-bit bins).
module tb_hist_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [12:0] magnitude;
    logic [3:0]  code;
    logic [3:0]  frac;
    logic        o_ready;

    logic         h_i_ready, h_o_valid, h_o_sat, h_o_err;
    logic [179:0] h_bin;
    logic         s_i_ready, s_o_valid, s_o_sat, s_o_err;
    logic [179:0] s_bin;
    logic         t_i_ready, t_o_valid, t_o_sat, t_o_err;
    logic [71:0]  t_bin;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hist_accum dut_hard (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(h_i_ready),
        .magnitude(magnitude), .code(code), .frac(frac),
        .o_valid(h_o_valid), .o_ready(o_ready), .bin(h_bin),
        .o_sat(h_o_sat), .o_err(h_o_err)
    );

    hist_accum #(.SOFT(1)) dut_soft (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(s_i_ready),
        .magnitude(magnitude), .code(code), .frac(frac),
        .o_valid(s_o_valid), .o_ready(o_ready), .bin(s_bin),
        .o_sat(s_o_sat), .o_err(s_o_err)
    );

    hist_accum #(.BIN_W(8)) dut_sat (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(t_i_ready),
        .magnitude(magnitude), .code(code), .frac(frac),
        .o_valid(t_o_valid), .o_ready(o_ready), .bin(t_bin),
        .o_sat(t_o_sat), .o_err(t_o_err)
    );

    function automatic int unsigned hbin(input logic [179:0] v, input int k);
        return 32'(v[k*20 +: 20]);
    endfunction

    function automatic int unsigned tbin(input logic [71:0] v, input int k);
        return 32'(v[k*8 +: 8]);
    endfunction

    // Presents one sample from a falling edge and returns on the falling edge after it is taken.
    task automatic push(input int m, input int c, input int f);
        int guard;
        guard     = 0;
        magnitude = 13'(m);
        code      = 4'(c);
        frac      = 4'(f);
        i_valid   = 1'b1;
        while (!h_i_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checks++; errors++;
            $display("FAIL push_timeout: i_ready=%0b, required 1", h_i_ready);
        end
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; i_valid = 1'b0; o_ready = 1'b0;
        magnitude = '0; code = '0; frac = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (h_o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %0b, required 0", h_o_valid); end
        checks++; if (h_bin !== '0) begin errors++; $display("FAIL reset_bin: got %h, required 0", h_bin); end
        checks++; if (h_o_sat !== 1'b0 || h_o_err !== 1'b0) begin errors++; $display("FAIL reset_flags: got sat=%0b err=%0b, required 0 0", h_o_sat, h_o_err); end
        checks++; if (h_i_ready !== 1'b1) begin errors++; $display("FAIL reset_i_ready: got %0b, required 1", h_i_ready); end
    endtask

    task automatic test_hard_vote;
        int unsigned exp;
        o_ready = 1'b1;
        for (int i = 0; i < 63; i++) push(1, i % 9, 0);
        checks++; if (h_o_valid !== 1'b0) begin errors++; $display("FAIL hard_early_valid: got %0b, required 0", h_o_valid); end
        push(1, 0, 0);
        checks++; if (h_o_valid !== 1'b1) begin errors++; $display("FAIL hard_latency: o_valid=%0b, required 1", h_o_valid); end
        for (int k = 0; k < 9; k++) begin
            exp = (k == 0) ? 8 : 7;
            checks++; if (hbin(h_bin, k) !== exp) begin errors++; $display("FAIL hard_bin%0d: got %0d, required %0d", k, hbin(h_bin, k), exp); end
        end
        checks++; if (h_o_sat !== 1'b0 || h_o_err !== 1'b0) begin errors++; $display("FAIL hard_flags: got sat=%0b err=%0b, required 0 0", h_o_sat, h_o_err); end
        @(negedge clk);
        checks++; if (h_o_valid !== 1'b0) begin errors++; $display("FAIL hard_drain: o_valid=%0b, required 0", h_o_valid); end
    endtask

    task automatic test_soft_vote;
        int unsigned exp;
        o_ready = 1'b1;
        for (int i = 0; i < 64; i++) push(16, 8, 4);
        checks++; if (s_o_valid !== 1'b1) begin errors++; $display("FAIL soft_valid: got %0b, required 1", s_o_valid); end
        for (int k = 0; k < 9; k++) begin
            exp = (k == 8) ? 768 : (k == 0) ? 256 : 0;
            checks++; if (hbin(s_bin, k) !== exp) begin errors++; $display("FAIL soft_wrap_bin%0d: got %0d, required %0d", k, hbin(s_bin, k), exp); end
        end
        checks++; if (hbin(h_bin, 8) !== 1024 || hbin(h_bin, 0) !== 0) begin errors++; $display("FAIL hard_wrap: got bin8=%0d bin0=%0d, required 1024 0", hbin(h_bin, 8), hbin(h_bin, 0)); end
        @(negedge clk);
        // frac=0 puts all of 100 low; frac=15 gives lo=6, hi=94.
        for (int i = 0; i < 32; i++) push(100, 2, 0);
        for (int i = 0; i < 32; i++) push(100, 2, 15);
        for (int k = 0; k < 9; k++) begin
            exp = (k == 2) ? 3392 : (k == 3) ? 3008 : 0;
            checks++; if (hbin(s_bin, k) !== exp) begin errors++; $display("FAIL soft_frac_bin%0d: got %0d, required %0d", k, hbin(s_bin, k), exp); end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        o_ready = 1'b0;
        for (int i = 0; i < 64; i++) push(2, 1, 0);
        checks++; if (h_o_valid !== 1'b1 || hbin(h_bin, 1) !== 128) begin errors++; $display("FAIL bp_first: got valid=%0b bin1=%0d, required 1 128", h_o_valid, hbin(h_bin, 1)); end
        for (int i = 0; i < 63; i++) push(3, 5, 0);
        checks++; if (hbin(h_bin, 1) !== 128 || hbin(h_bin, 5) !== 0) begin errors++; $display("FAIL bp_hold: got bin1=%0d bin5=%0d, required 128 0", hbin(h_bin, 1), hbin(h_bin, 5)); end
        magnitude = 13'(3); code = 4'(5); frac = '0; i_valid = 1'b1;
        checks++; if (h_i_ready !== 1'b0) begin errors++; $display("FAIL bp_stall: i_ready=%0b, required 0", h_i_ready); end
        repeat (3) @(negedge clk);
        checks++; if (h_i_ready !== 1'b0 || h_o_valid !== 1'b1 || hbin(h_bin, 1) !== 128) begin errors++; $display("FAIL bp_stable: got ready=%0b valid=%0b bin1=%0d, required 0 1 128", h_i_ready, h_o_valid, hbin(h_bin, 1)); end
        o_ready = 1'b1;
        #1;
        checks++; if (h_i_ready !== 1'b1) begin errors++; $display("FAIL bp_release: i_ready=%0b, required 1", h_i_ready); end
        @(negedge clk);
        i_valid = 1'b0;
        checks++; if (h_o_valid !== 1'b1 || hbin(h_bin, 5) !== 192 || hbin(h_bin, 1) !== 0) begin errors++; $display("FAIL bp_second: got valid=%0b bin5=%0d bin1=%0d, required 1 192 0", h_o_valid, hbin(h_bin, 5), hbin(h_bin, 1)); end
        @(negedge clk);
        checks++; if (h_o_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: o_valid=%0b, required 0", h_o_valid); end
    endtask

    task automatic test_saturation;
        o_ready = 1'b1;
        for (int i = 0; i < 64; i++) push(255, 3, 0);
        checks++; if (tbin(t_bin, 3) !== 255 || t_o_sat !== 1'b1) begin errors++; $display("FAIL sat_bin3: got %0d sat=%0b, required 255 1", tbin(t_bin, 3), t_o_sat); end
        checks++; if (hbin(h_bin, 3) !== 16320 || h_o_sat !== 1'b0) begin errors++; $display("FAIL wide_bin3: got %0d sat=%0b, required 16320 0", hbin(h_bin, 3), h_o_sat); end
        @(negedge clk);
        for (int i = 0; i < 64; i++) push(1, 3, 0);
        checks++; if (tbin(t_bin, 3) !== 64 || t_o_sat !== 1'b0) begin errors++; $display("FAIL sat_clear: got %0d sat=%0b, required 64 0", tbin(t_bin, 3), t_o_sat); end
        @(negedge clk);
    endtask

    task automatic test_illegal_code;
        int unsigned exp;
        o_ready = 1'b1;
        for (int i = 0; i < 63; i++) begin
            if (i == 10) push(50, 12, 0);
            else         push(1, 0, 0);
        end
        checks++; if (h_o_valid !== 1'b0) begin errors++; $display("FAIL err_early_valid: got %0b, required 0", h_o_valid); end
        push(1, 0, 0);
        checks++; if (h_o_valid !== 1'b1 || h_o_err !== 1'b1) begin errors++; $display("FAIL err_flag: got valid=%0b err=%0b, required 1 1", h_o_valid, h_o_err); end
        for (int k = 0; k < 9; k++) begin
            exp = (k == 0) ? 63 : 0;
            checks++; if (hbin(h_bin, k) !== exp) begin errors++; $display("FAIL err_bin%0d: got %0d, required %0d", k, hbin(h_bin, k), exp); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_cell;
        o_ready = 1'b0;
        for (int i = 0; i < 64; i++) push(5, 7, 0);
        checks++; if (h_o_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre: o_valid=%0b, required 1", h_o_valid); end
        for (int i = 0; i < 30; i++) push(9, 4, 0);
        // Accept is offered during reset; reset must win.
        rst = 1'b1; magnitude = 13'(9); code = 4'(4); i_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; i_valid = 1'b0;
        checks++; if (h_o_valid !== 1'b0 || h_bin !== '0 || h_o_sat !== 1'b0 || h_o_err !== 1'b0) begin errors++; $display("FAIL rmid_outputs: got valid=%0b bin=%h sat=%0b err=%0b, required all 0", h_o_valid, h_bin, h_o_sat, h_o_err); end
        checks++; if (h_i_ready !== 1'b1) begin errors++; $display("FAIL rmid_i_ready: got %0b, required 1", h_i_ready); end
        o_ready = 1'b1;
        for (int i = 0; i < 63; i++) push(2, 6, 0);
        checks++; if (h_o_valid !== 1'b0) begin errors++; $display("FAIL rmid_early_valid: got %0b, required 0", h_o_valid); end
        push(2, 6, 0);
        checks++; if (h_o_valid !== 1'b1 || hbin(h_bin, 6) !== 128) begin errors++; $display("FAIL rmid_bin6: got valid=%0b bin6=%0d, required 1 128", h_o_valid, hbin(h_bin, 6)); end
        checks++; if (hbin(h_bin, 4) !== 0 || hbin(h_bin, 7) !== 0 || h_o_err !== 1'b0) begin errors++; $display("FAIL rmid_residue: got bin4=%0d bin7=%0d err=%0b, required 0 0 0", hbin(h_bin, 4), hbin(h_bin, 7), h_o_err); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_hard_vote();
        test_soft_vote();
        test_back_to_back();
        test_saturation();
        test_illegal_code();
        test_reset_mid_cell();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
